// File: rtl/mips_pkg.sv
// Shared MIPS-subset encodings: ALU control codes, opcode/funct values and
// the decoded-control bundle passed from the decoder to the issue stage.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100,
        ALU_SLL = 4'b1111
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        BSEL_RT,
        BSEL_SEXT,
        BSEL_ZEXT,
        BSEL_SHAMT
    } bsel_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    a_is_rt;
        bsel_e   b_sel;
        logic    dest_is_rt;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    is_branch;
        logic    ovf_trap;
    } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decoder: ALU control code, operand selects,
// EX/MEM control bits and an illegal-instruction flag.
module alu_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec,
    output logic       illegal
);

    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        dec.alu_op     = ALU_ADD;
        dec.b_sel      = BSEL_RT;
        dec.dest_is_rt = 1'b1;
        dec.reg_write  = 1'b1;
        unique case (opcode)
            OP_RTYPE: begin
                dec.dest_is_rt = 1'b0;
                unique case (funct)
                    FN_ADD:  begin dec.alu_op = ALU_ADD; dec.ovf_trap = 1'b1; end
                    FN_ADDU: dec.alu_op = ALU_ADD;
                    FN_SUB:  begin dec.alu_op = ALU_SUB; dec.ovf_trap = 1'b1; end
                    FN_SUBU: dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_NOR:  dec.alu_op = ALU_NOR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    FN_SLL: begin
                        dec.alu_op  = ALU_SLL;
                        dec.a_is_rt = 1'b1;
                        dec.b_sel   = BSEL_SHAMT;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec.b_sel    = BSEL_SEXT;
                dec.ovf_trap = 1'b1;
            end
            OP_ADDIU: dec.b_sel = BSEL_SEXT;
            OP_SLTI: begin
                dec.alu_op = ALU_SLT;
                dec.b_sel  = BSEL_SEXT;
            end
            OP_ANDI: begin
                dec.alu_op = ALU_AND;
                dec.b_sel  = BSEL_ZEXT;
            end
            OP_ORI: begin
                dec.alu_op = ALU_OR;
                dec.b_sel  = BSEL_ZEXT;
            end
            OP_LW: begin
                dec.b_sel    = BSEL_SEXT;
                dec.mem_read = 1'b1;
            end
            OP_SW: begin
                dec.b_sel     = BSEL_SEXT;
                dec.mem_write = 1'b1;
                dec.reg_write = 1'b0;
            end
            OP_BEQ: begin
                dec.alu_op    = ALU_SUB;
                dec.is_branch = 1'b1;
                dec.reg_write = 1'b0;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec = '0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, operand forwarding and operand select feeding a
// single-entry valid/ready pipeline slot whose outputs drive the ALU directly.
module alu_issue_stage
    import mips_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic [4:0]          shamt,
    input  logic [15:0]         imm16,
    input  logic [REG_BITS-1:0] rs_idx,
    input  logic [REG_BITS-1:0] rt_idx,
    input  logic [REG_BITS-1:0] rd_idx,
    input  logic [XLEN-1:0]     rs_val,
    input  logic [XLEN-1:0]     rt_val,
    input  logic                exm_we,
    input  logic [REG_BITS-1:0] exm_idx,
    input  logic [XLEN-1:0]     exm_data,
    input  logic                mwb_we,
    input  logic [REG_BITS-1:0] mwb_idx,
    input  logic [XLEN-1:0]     mwb_data,
    input  logic                flush,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [3:0]          alu_ctrl,
    output logic [XLEN-1:0]     alu_a,
    output logic [XLEN-1:0]     alu_b,
    output logic [XLEN-1:0]     store_data,
    output logic [REG_BITS-1:0] dest_idx,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                is_branch,
    output logic                ovf_trap,
    output logic                illegal_op
);

    dec_t dec;
    logic dec_illegal;

    alu_ctrl_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .dec     (dec),
        .illegal (dec_illegal)
    );

    logic [XLEN-1:0]     fwd_rs, fwd_rt, op_a, op_b;
    logic [REG_BITS-1:0] dest_sel;
    logic                capture, load;

    always_comb begin
        if (exm_we && exm_idx == rs_idx && rs_idx != '0)      fwd_rs = exm_data;
        else if (mwb_we && mwb_idx == rs_idx && rs_idx != '0) fwd_rs = mwb_data;
        else                                                  fwd_rs = rs_val;
        if (exm_we && exm_idx == rt_idx && rt_idx != '0)      fwd_rt = exm_data;
        else if (mwb_we && mwb_idx == rt_idx && rt_idx != '0) fwd_rt = mwb_data;
        else                                                  fwd_rt = rt_val;
    end

    always_comb begin
        op_a = dec.a_is_rt ? fwd_rt : fwd_rs;
        unique case (dec.b_sel)
            BSEL_SEXT:  op_b = {{(XLEN-16){imm16[15]}}, imm16};
            BSEL_ZEXT:  op_b = {{(XLEN-16){1'b0}}, imm16};
            BSEL_SHAMT: op_b = {{(XLEN-5){1'b0}}, shamt};
            default:    op_b = fwd_rt;
        endcase
        dest_sel = dec.dest_is_rt ? rt_idx : rd_idx;
    end

    logic                out_valid_q, out_valid_d;
    logic [3:0]          alu_ctrl_q, alu_ctrl_d;
    logic [XLEN-1:0]     alu_a_q, alu_a_d;
    logic [XLEN-1:0]     alu_b_q, alu_b_d;
    logic [XLEN-1:0]     store_data_q, store_data_d;
    logic [REG_BITS-1:0] dest_idx_q, dest_idx_d;
    logic                reg_write_q, reg_write_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                is_branch_q, is_branch_d;
    logic                ovf_trap_q, ovf_trap_d;
    logic                illegal_op_q, illegal_op_d;

    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready;
    assign load     = capture && !flush && !dec_illegal;

    always_comb begin
        out_valid_d  = out_valid_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        store_data_d = store_data_q;
        dest_idx_d   = dest_idx_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        is_branch_d  = is_branch_q;
        ovf_trap_d   = ovf_trap_q;
        illegal_op_d = capture && !flush && dec_illegal;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d  = 1'b1;
            alu_ctrl_d   = dec.alu_op;
            alu_a_d      = op_a;
            alu_b_d      = op_b;
            store_data_d = fwd_rt;
            dest_idx_d   = dest_sel;
            reg_write_d  = dec.reg_write && (dest_sel != '0);
            mem_read_d   = dec.mem_read;
            mem_write_d  = dec.mem_write;
            is_branch_d  = dec.is_branch;
            ovf_trap_d   = dec.ovf_trap;
        end else if (capture || out_ready) begin
            out_valid_d = 1'b0;
        end

        // An empty slot must never present live control to EX/MEM.
        if (!out_valid_d) begin
            alu_ctrl_d  = '0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            is_branch_d = 1'b0;
            ovf_trap_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            alu_ctrl_q   <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            store_data_q <= '0;
            dest_idx_q   <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            is_branch_q  <= 1'b0;
            ovf_trap_q   <= 1'b0;
            illegal_op_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            store_data_q <= store_data_d;
            dest_idx_q   <= dest_idx_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            is_branch_q  <= is_branch_d;
            ovf_trap_q   <= ovf_trap_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign store_data = store_data_q;
    assign dest_idx   = dest_idx_q;
    assign reg_write  = reg_write_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign is_branch  = is_branch_q;
    assign ovf_trap   = ovf_trap_q;
    assign illegal_op = illegal_op_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX boundary block that produces every ALU input: decodes opcode/funct into the 4-bit ALU control code and selects operands A/B.
- Applies register forwarding and registers the result into a single-entry ID/EX pipeline slot with a valid/ready handshake.
- The EX stage consumes its outputs directly; alu_ctrl/alu_a/alu_b feed the ALU's Ctrl/A/B unchanged.

Parameters:
- XLEN, 32, datapath width
- REG_BITS, 5, register index width

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  decoded instruction fields present
- in_ready  output  1  stage can accept this cycle
- opcode  input  6  instruction[31:26]
- funct  input  6  instruction[5:0]
- shamt  input  5  instruction[10:6]
- imm16  input  16  instruction[15:0]
- rs_idx, rt_idx, rd_idx  input  REG_BITS each  register indices
- rs_val, rt_val  input  XLEN each  register-file read data
- exm_we, exm_idx, exm_data  input  1/REG_BITS/XLEN  EX/MEM writeback forward
- mwb_we, mwb_idx, mwb_data  input  1/REG_BITS/XLEN  MEM/WB writeback forward
- flush  input  1  kill the slot (branch taken)
- out_ready  input  1  EX stage accepts
- out_valid  output  1  slot holds an instruction
- alu_ctrl  output  4  ALU control code
- alu_a, alu_b  output  XLEN each  ALU operands
- store_data  output  XLEN  forwarded rt value for sw
- dest_idx  output  REG_BITS  write register
- reg_write, mem_read, mem_write, is_branch, ovf_trap  output  1 each  EX/MEM control
- illegal_op  output  1  one-cycle pulse on an unsupported instruction

Behaviour:
- Reset: every output register is 0, including out_valid. illegal_op is 0. in_ready is 1 after reset.
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, SLL 1111.
- R-type (opcode 0x00), by funct:
  - 0x20 add: ADD, ovf_trap=1
  - 0x21 addu: ADD
  - 0x22 sub: SUB, ovf_trap=1
  - 0x23 subu: SUB
  - 0x24 and: AND
  - 0x25 or: OR
  - 0x27 nor: NOR
  - 0x2A slt: SLT
  - 0x00 sll: SLL, A=rt, B=zero-extended shamt
  - Otherwise A=rs, B=rt; dest=rd.
- I-type, dest=rt, B=imm:
  - addi 0x08: ADD, sign-extended imm, ovf_trap=1
  - addiu 0x09: ADD, sign-extended imm
  - slti 0x0A: SLT, sign-extended imm
  - andi 0x0C: AND, zero-extended imm
  - ori 0x0D: OR, zero-extended imm
  - lw 0x23: ADD, sign-extended imm, mem_read=1
  - sw 0x2B: ADD, sign-extended imm, mem_write=1, reg_write=0
  - beq 0x04: SUB, A=rs, B=rt, is_branch=1, reg_write=0
- reg_write is forced to 0 whenever dest_idx==0; sll $0,$0,0 (nop) therefore writes nothing.
- Forwarding, per source operand, in priority order:
  - EX/MEM if exm_we && exm_idx==src && src!=0
  - else MEM/WB under the same rule
  - else the register-file value
  - Applied before the immediate/shamt select; store_data uses the forwarded rt.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Capture happens when in_valid && in_ready; out_valid is then set the next cycle (latency 1).
  - The slot is held stable while out_valid && !out_ready.
  - If out_ready with no new capture, out_valid clears.
- Illegal instruction:
  - Captured as a bubble: out_valid=0, all control bits 0.
  - illegal_op pulses high for exactly one cycle, the cycle after capture.
- Flush:
  - The next cycle has out_valid=0, regardless of in_valid or stall.
  - Flush wins over a simultaneous capture; the incoming instruction is discarded, and any illegal_op it would raise is suppressed.
- rst asserted mid-stall clears the slot the next cycle; the held instruction is lost.
- Datapath payload registers need not be cleared when out_valid=0, except that control bits must be 0.

Decomposition:
- Shared package mips_pkg holds:
  - ALU code constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_SLL
  - opcode and funct constants
- One combinational sub-module, alu_ctrl_decode: opcode/funct in, alu_ctrl plus control bits plus illegal flag out.
- Forward muxes and the pipeline register stay in the top.

Test Plan:
- After rst, add $3,$1,$2 with rs_val=5, rt_val=7, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0010, alu_a=5, alu_b=7, dest_idx=3, reg_write=1, ovf_trap=1.
- andi $4,$1,0xFFFF and addi $4,$1,0xFFFF -> alu_b=0x0000FFFF with ctrl 0000, then alu_b=0xFFFFFFFF with ctrl 0010.
- sll $2,$5,4 with rt_val=0x1 -> alu_ctrl=1111, alu_a=0x1, alu_b=4. A following sll $0,$0,0 -> reg_write=0.
- Forwarding: rs_idx=6, exm_we=1/exm_idx=6/exm_data=0xAA, and mwb also targeting 6 with 0xBB -> alu_a=0xAA. Same stimulus with rs_idx=0 -> register-file value used.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. out_ready=1 -> new instruction appears on the next cycle, with none lost or duplicated.
- flush and capture in the same cycle -> out_valid=0 next cycle. Opcode 0x3F -> illegal_op=1 for one cycle, out_valid=0.
